seven_seg_scanner: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 20 ++
 rtl/seven_seg_hex_to_seg.sv | 17 +
 rtl/seven_seg_scanner.sv | 113 +++++++++++
 tb/tb_seven_seg_scanner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scanner.
package seven_seg_pkg;

  // All segments off (active-low outputs).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex glyph table, segments g..a active-low, entry n at bits [7n+6:7n].
  localparam logic [16*7-1:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seven_seg_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  logic [6:0] w_base;

  // Bit offset of the selected glyph inside the packed table.
  always_comb begin
    w_base = {3'b000, i_nibble} * 7'd7;
    o_seg  = HEX_SEG_TABLE[w_base +: 7];
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with per-digit
// blanking, decimal points, blink and PWM brightness. All pins registered.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,   // 2..8
  parameter int DIV_W        = 18,  // each digit slot lasts 2^DIV_W cycles
  parameter int BR_W         = 3,   // must not exceed DIV_W
  parameter int BLINK_FRAMES = 64   // frames per blink half-period, >= 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic [BR_W-1:0]         brightness,
  output logic [6:0]              display,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   AN
);

  localparam int IDX_W  = clog2_min1(NUM_DIGITS);
  localparam int FCNT_W = clog2_min1(BLINK_FRAMES);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FCNT_W-1:0] LAST_FRAME = FCNT_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [FCNT_W-1:0]     r_fcnt;
  logic                  r_blink_on;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_display;
  logic                  r_dp;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic [BR_W-1:0]       w_phase;
  logic                  w_pwm_en;
  logic                  w_vis;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg;
  logic [NUM_DIGITS-1:0] w_an_sel;

  // Slot counter, digit index, frame counter and blink phase.
  // A blink toggle lands on the same edge that starts the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_fcnt     <= '0;
      r_blink_on <= 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_slot_end) begin
        if (r_idx == LAST_IDX) r_idx <= '0;
        else                   r_idx <= r_idx + 1'b1;
      end
      if (w_frame_end) begin
        if (r_fcnt == LAST_FRAME) begin
          r_fcnt     <= '0;
          r_blink_on <= ~r_blink_on;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end
    end
  end

  // Slot/frame boundaries, PWM gate and per-digit visibility.
  always_comb begin
    w_slot_end  = &r_cnt;
    w_frame_end = w_slot_end && (r_idx == LAST_IDX);
    w_phase     = r_cnt[DIV_W-1 -: BR_W];
    w_pwm_en    = (&brightness) || (w_phase < brightness);
    w_vis       = w_pwm_en && !blank[r_idx] && !(blink[r_idx] && !r_blink_on);
    w_nibble    = digits[{r_idx, 2'b00} +: 4];
  end

  // One-hot active-low anode for the current digit.
  always_comb begin
    w_an_sel        = '1;
    w_an_sel[r_idx] = 1'b0;
  end

  // Single decoder on the muxed nibble.
  hex_to_seg u_hex_to_seg (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  // Output register: anode and segments always switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an      <= '1;
      r_display <= SEG_BLANK;
      r_dp      <= 1'b1;
    end else if (w_vis) begin
      r_an      <= w_an_sel;
      r_display <= w_seg;
      r_dp      <= ~dp[r_idx];
    end else begin
      r_an      <= '1;
      r_display <= SEG_BLANK;
      r_dp      <= 1'b1;
    end
  end

  assign AN      = r_an;
  assign display = r_display;
  assign dp_out  = r_dp;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: fixed vectors, hand sequences and random
// stimulus, all checked against a cycle-count reference model.
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int DW = 2;
  localparam int BW = 2;
  localparam int BF = 2;

  typedef logic [ND+7:0] out_t;   // {AN, display, dp_out}
  localparam out_t IDLE = {{ND{1'b1}}, 7'h7F, 1'b1};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [4*ND-1:0] digits = '0;
  logic [ND-1:0]   blank = '0;
  logic [ND-1:0]   dp = '0;
  logic [ND-1:0]   blink = '0;
  logic [BW-1:0]   brightness = '0;
  logic [6:0]      display;
  logic            dp_out;
  logic [ND-1:0]   an;

  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  out_t exp_q[$];
  int   t;        // cycles since reset release (state time)
  int   checks = 0;
  int   errors = 0;

  seven_seg_scanner #(
    .NUM_DIGITS   (ND),
    .DIV_W        (DW),
    .BR_W         (BW),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .blank      (blank),
    .dp         (dp),
    .blink      (blink),
    .brightness (brightness),
    .display    (display),
    .dp_out     (dp_out),
    .AN         (an)
  );

  // clock
  always #5 clk = ~clk;

  // Reference: everything derived from elapsed cycles since reset.
  function automatic out_t model(input int tt);
    int slot_len, cnt, idx, frame, phase;
    bit blink_on, pwm, vis;
    logic [ND-1:0] a;
    slot_len = 1 << DW;
    cnt      = tt % slot_len;
    idx      = (tt / slot_len) % ND;
    frame    = tt / (slot_len * ND);
    blink_on = ((frame / BF) % 2) == 0;
    phase    = cnt >> (DW - BW);
    pwm      = (brightness == {BW{1'b1}}) || (phase < int'(brightness));
    vis      = pwm && !blank[idx] && !(blink[idx] && !blink_on);
    if (!vis) return IDLE;
    a      = '1;
    a[idx] = 1'b0;
    return {a, seg_ref[digits[idx*4 +: 4]], ~dp[idx]};
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got AN=%b disp=%h dp=%b, expected AN=%b disp=%h dp=%b",
               name, t, got[ND+7:8], got[7:1], got[0], exp[ND+7:8], exp[7:1], exp[0]);
    end
  endtask

  // One clock: predict, advance, compare against the scoreboard.
  task automatic step(input string name);
    exp_q.push_back(rst ? IDLE : model(t));
    @(posedge clk);
    #1;
    check(name, {an, display, dp_out}, exp_q.pop_front());
    t = rst ? 0 : t + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step("reset");
    rst = 1'b0;
  endtask

  // Step until the outputs show state time k.
  task automatic run_to(input int k, input string name);
    while (t <= k) step(name);
  endtask

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic [3:0]  blink;
    logic [1:0]  br;
    int          k;
    logic [3:0]  an;
    logic [6:0]  disp;
    logic        dpo;
  } vec_t;

  vec_t vecs [19];

  initial begin
    vecs[0]  = '{16'h3A7F, 4'h0, 4'h0, 4'h0, 2'd3, 0,  4'he, 7'h0E, 1'b1};
    vecs[1]  = '{16'h3A7F, 4'h0, 4'h0, 4'h0, 2'd3, 3,  4'he, 7'h0E, 1'b1};
    vecs[2]  = '{16'h3A7F, 4'h0, 4'h0, 4'h0, 2'd3, 4,  4'hd, 7'h78, 1'b1};
    vecs[3]  = '{16'h3A7F, 4'h0, 4'h0, 4'h0, 2'd3, 8,  4'hb, 7'h08, 1'b1};
    vecs[4]  = '{16'h3A7F, 4'h0, 4'h0, 4'h0, 2'd3, 12, 4'h7, 7'h30, 1'b1};
    vecs[5]  = '{16'h3A7F, 4'h0, 4'h0, 4'h0, 2'd3, 16, 4'he, 7'h0E, 1'b1};
    vecs[6]  = '{16'h3A7F, 4'h0, 4'h0, 4'h0, 2'd1, 4,  4'hd, 7'h78, 1'b1};
    vecs[7]  = '{16'h3A7F, 4'h0, 4'h0, 4'h0, 2'd1, 5,  4'hf, 7'h7F, 1'b1};
    vecs[8]  = '{16'h3A7F, 4'h0, 4'h0, 4'h0, 2'd1, 7,  4'hf, 7'h7F, 1'b1};
    vecs[9]  = '{16'h3A7F, 4'h0, 4'h0, 4'h0, 2'd0, 0,  4'hf, 7'h7F, 1'b1};
    vecs[10] = '{16'h3A7F, 4'h0, 4'h0, 4'h0, 2'd0, 12, 4'hf, 7'h7F, 1'b1};
    vecs[11] = '{16'h3A7F, 4'h4, 4'h1, 4'h0, 2'd3, 8,  4'hf, 7'h7F, 1'b1};
    vecs[12] = '{16'h3A7F, 4'h4, 4'h1, 4'h0, 2'd3, 0,  4'he, 7'h0E, 1'b0};
    vecs[13] = '{16'h3A7F, 4'h4, 4'h1, 4'h0, 2'd3, 4,  4'hd, 7'h78, 1'b1};
    vecs[14] = '{16'h3A7F, 4'h0, 4'h0, 4'h2, 2'd3, 4,  4'hd, 7'h78, 1'b1};
    vecs[15] = '{16'h3A7F, 4'h0, 4'h0, 4'h2, 2'd3, 20, 4'hd, 7'h78, 1'b1};
    vecs[16] = '{16'h3A7F, 4'h0, 4'h0, 4'h2, 2'd3, 36, 4'hf, 7'h7F, 1'b1};
    vecs[17] = '{16'h3A7F, 4'h0, 4'h0, 4'h2, 2'd3, 40, 4'hb, 7'h08, 1'b1};
    vecs[18] = '{16'h3A7F, 4'h0, 4'h0, 4'h2, 2'd3, 68, 4'hd, 7'h78, 1'b1};

    // table-driven vectors
    for (int i = 0; i < 19; i++) begin
      digits     = vecs[i].digits;
      blank      = vecs[i].blank;
      dp         = vecs[i].dp;
      blink      = vecs[i].blink;
      brightness = vecs[i].br;
      do_reset();
      run_to(vecs[i].k, "vec_walk");
      check($sformatf("vec%0d", i), {an, display, dp_out},
            {vecs[i].an, vecs[i].disp, vecs[i].dpo});
    end

    // first lit digit exactly one cycle after reset release
    digits = 16'h3A7F; blank = '0; dp = '0; blink = '0; brightness = 2'd3;
    do_reset();
    step("first_cycle");
    check("first_an", {an, display, dp_out}, {4'he, 7'h0E, 1'b1});

    // mid-scan reset during digit 2 while blink is in its off phase
    blink = 4'b0010;
    do_reset();
    run_to(41, "pre_reset");
    rst = 1'b1;
    step("mid_reset");
    check("mid_reset_idle", {an, display, dp_out}, IDLE);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step("restart");
      check($sformatf("restart_d0_%0d", i), {an, display, dp_out}, {4'he, 7'h0E, 1'b1});
    end
    step("restart");
    check("restart_d1_blink_on", {an, display, dp_out}, {4'hd, 7'h78, 1'b1});

    // live update of digit 1 mid-slot
    blink = '0;
    do_reset();
    run_to(4, "live_pre");
    check("live_before", {an, display, dp_out}, {4'hd, 7'h78, 1'b1});
    digits = 16'h3A5F;
    step("live");
    check("live_after", {an, display, dp_out}, {4'hd, 7'h12, 1'b1});

    // random stimulus against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      digits = 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        blank      = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        dp         = 4'($urandom_range(0, 15));
        blink      = 4'($urandom_range(0, 15));
        brightness = 2'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 499) == 0);
      step("random");
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
